fetch_sequencer: RTL and testbench

//  Sequences instruction fetch for the CPU front end: owns the PC, issues
//  req/ready reads to a multi-cycle instruction ROM, and presents one

---
 rtl/fetch_sequencer_if.sv | 22 ++
 rtl/fetch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Request/ready bus between the fetch sequencer (master) and the instruction ROM (slave).
// The address is held stable for as long as the request stays up.
interface fetch_sequencer_if;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic        rom_rdy;
   logic [31:0] rom_data;

   modport master (
      output rom_ce,
      output rom_addr,
      input  rom_rdy,
      input  rom_data
   );

   modport slave (
      input  rom_ce,
      input  rom_addr,
      output rom_rdy,
      output rom_data
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: owns the PC, reads a multi-cycle instruction ROM and hands one
// instruction at a time to decode, resolving redirects, stalls, in-flight flushes and timeouts.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      excpt,
   input  logic [31:0]               ejpc,
   input  logic                      jCe,
   input  logic [31:0]               jAddr,
   input  logic                      stall,
   fetch_sequencer_if.master         rom,
   output logic                      inst_valid,
   output logic [31:0]               inst,
   output logic [31:0]               inst_pc,
   output logic                      fetch_err
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_ISSUE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   inst_q, inst_d;
   logic [31:0]   inst_pc_q, inst_pc_d;
   logic [31:0]   pend_q, pend_d;
   logic          pend_exc_q, pend_exc_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          fetch_err_q, fetch_err_d;

   logic          redirect;
   logic [31:0]   target;
   logic          tmo_hit;
   logic [31:0]   drain_tgt;
   logic          drain_exc;
   logic          rom_ce_c;
   logic          inst_valid_c;

   assign redirect = excpt | jCe;
   assign target   = excpt ? ejpc : jAddr;
   assign tmo_hit  = (tmo_q == TMO_LAST);

   // The pending-redirect flag is the DRAIN state itself; pend_exc_q records its source.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         inst_q      <= '0;
         inst_pc_q   <= '0;
         pend_q      <= '0;
         pend_exc_q  <= 1'b0;
         tmo_q       <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         inst_q      <= inst_d;
         inst_pc_q   <= inst_pc_d;
         pend_q      <= pend_d;
         pend_exc_q  <= pend_exc_d;
         tmo_q       <= tmo_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_d      = inst_q;
      inst_pc_d   = inst_pc_q;
      pend_d      = pend_q;
      pend_exc_d  = pend_exc_q;
      tmo_d       = tmo_q;
      fetch_err_d = 1'b0;

      // An exception always replaces the pending target; a jump only replaces a jump.
      drain_tgt = pend_q;
      drain_exc = pend_exc_q;
      if (excpt) begin
         drain_tgt = ejpc;
         drain_exc = 1'b1;
      end else if (jCe && !pend_exc_q) begin
         drain_tgt = jAddr;
      end

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            tmo_d   = '0;
         end
         S_FETCH: begin
            if (rom.rom_rdy) begin
               if (redirect) begin
                  pc_d    = target;
                  state_d = S_IDLE;
               end else begin
                  inst_d    = rom.rom_data;
                  inst_pc_d = pc_q;
                  state_d   = S_ISSUE;
               end
            end else if (tmo_hit) begin
               fetch_err_d = 1'b1;
               state_d     = S_IDLE;
               if (redirect) begin
                  pc_d = target;
               end
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (redirect) begin
                  pend_d     = target;
                  pend_exc_d = excpt;
                  state_d    = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            pend_d     = drain_tgt;
            pend_exc_d = drain_exc;
            if (rom.rom_rdy || tmo_hit) begin
               pc_d        = drain_tgt;
               pend_exc_d  = 1'b0;
               fetch_err_d = !rom.rom_rdy;
               state_d     = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_ISSUE: begin
            if (redirect) begin
               pc_d    = target;
               state_d = S_IDLE;
            end else if (!stall) begin
               pc_d    = pc_q + 32'(PC_STEP);
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      rom_ce_c     = 1'b0;
      inst_valid_c = 1'b0;
      case (state_q)
         S_FETCH, S_DRAIN: rom_ce_c     = 1'b1;
         S_ISSUE:          inst_valid_c = 1'b1;
         default:          rom_ce_c     = 1'b0;
      endcase
   end

   assign rom.rom_ce   = rom_ce_c;
   assign rom.rom_addr = pc_q;
   assign inst_valid   = inst_valid_c;
   assign inst         = inst_q;
   assign inst_pc      = inst_pc_q;
   assign fetch_err    = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Cycle-by-cycle directed bench for fetch_sequencer: a vector table for fetch/stall/redirect
// traffic, then hand sequences for FETCH/DRAIN timeouts and an asynchronous mid-fetch reset.
module tb_fetch_sequencer;

   typedef struct {
      logic        rdy;
      logic [31:0] data;
      logic        stall;
      logic        jce;
      logic [31:0] jaddr;
      logic        exc;
      logic [31:0] epc;
      logic        ce;
      logic [31:0] addr;
      logic        iv;
      logic [31:0] ipc;
      logic [31:0] ins;
      logic        err;
   } vec_t;

   localparam logic [31:0] D00 = 32'h1111_0000;
   localparam logic [31:0] D04 = 32'h2222_0004;
   localparam logic [31:0] D08 = 32'h3333_0008;
   localparam logic [31:0] DBF = 32'hDEAD_BEEF;
   localparam logic [31:0] B80 = 32'h4444_0080;
   localparam logic [31:0] C20 = 32'h5555_0020;
   localparam logic [31:0] D70 = 32'h6666_0700;
   localparam logic [31:0] E50 = 32'h7777_0500;
   localparam logic [31:0] FFC = 32'h8888_FFFC;
   localparam logic [31:0] X99 = 32'h9999_9999;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        excpt, jce, stall;
   logic [31:0] ejpc, jaddr;
   logic        iv, err;
   logic [31:0] inst, ipc;
   int          total = 0;
   int          bad = 0;
   vec_t        tv[$];

   always #5 clk = ~clk;

   fetch_sequencer_if rom ();

   fetch_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .excpt      (excpt),
      .ejpc       (ejpc),
      .jCe        (jce),
      .jAddr      (jaddr),
      .stall      (stall),
      .rom        (rom),
      .inst_valid (iv),
      .inst       (inst),
      .inst_pc    (ipc),
      .fetch_err  (err)
   );

   function automatic vec_t mk(logic rdy, logic [31:0] data, logic st, logic jc, logic [31:0] ja,
                               logic ex, logic [31:0] ep, logic ce, logic [31:0] addr, logic v,
                               logic [31:0] pc, logic [31:0] ins, logic er);
      vec_t r;
      r.rdy = rdy; r.data = data; r.stall = st; r.jce = jc; r.jaddr = ja; r.exc = ex; r.epc = ep;
      r.ce = ce; r.addr = addr; r.iv = v; r.ipc = pc; r.ins = ins; r.err = er;
      return r;
   endfunction

   task automatic drive(input vec_t v);
      rom.rom_rdy  = v.rdy;
      rom.rom_data = v.data;
      stall        = v.stall;
      jce          = v.jce;
      jaddr        = v.jaddr;
      excpt        = v.exc;
      ejpc         = v.epc;
   endtask

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, exp);
      end
   endtask

   initial begin
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Columns: rdy data stall jCe jAddr excpt ejpc | rom_ce rom_addr inst_valid inst_pc inst fetch_err
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'h0,   0, 32'h0,   0,   0)); // c0 IDLE
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      1, 32'h0,   0, 32'h0,   0,   0));
      tv.push_back(mk(1, D00, 0, 0, 0,      0, 0,      1, 32'h0,   0, 32'h0,   0,   0));
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'h0,   1, 32'h0,   D00, 0)); // c3 ISSUE pc 0
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'h4,   0, 32'h0,   D00, 0));
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      1, 32'h4,   0, 32'h0,   D00, 0));
      tv.push_back(mk(1, D04, 0, 0, 0,      0, 0,      1, 32'h4,   0, 32'h0,   D00, 0));
      for (int k = 0; k < 5; k++)                                                        // c7..c11 stalled
         tv.push_back(mk(0, 0, 1, 0, 0,     0, 0,      0, 32'h4,   1, 32'h4,   D04, 0));
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'h4,   1, 32'h4,   D04, 0));
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'h8,   0, 32'h4,   D04, 0));
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      1, 32'h8,   0, 32'h4,   D04, 0));
      tv.push_back(mk(1, D08, 0, 0, 0,      0, 0,      1, 32'h8,   0, 32'h4,   D04, 0));
      tv.push_back(mk(0, 0,   0, 1, 32'h100, 0, 0,     0, 32'h8,   1, 32'h8,   D08, 0)); // c16 jump in ISSUE
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'h100, 0, 32'h8,   D08, 0));
      tv.push_back(mk(0, 0,   0, 1, 32'h200, 0, 0,     1, 32'h100, 0, 32'h8,   D08, 0)); // jump -> DRAIN
      tv.push_back(mk(0, 0,   0, 0, 0,      1, 32'h80, 1, 32'h100, 0, 32'h8,   D08, 0)); // excpt overwrites
      tv.push_back(mk(0, 0,   0, 1, 32'h300, 0, 0,     1, 32'h100, 0, 32'h8,   D08, 0)); // jump ignored
      tv.push_back(mk(1, DBF, 0, 0, 0,      0, 0,      1, 32'h100, 0, 32'h8,   D08, 0)); // data discarded
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'h80,  0, 32'h8,   D08, 0));
      tv.push_back(mk(1, B80, 0, 0, 0,      0, 0,      1, 32'h80,  0, 32'h8,   D08, 0)); // zero latency
      tv.push_back(mk(0, 0,   1, 0, 0,      1, 32'h40, 0, 32'h80,  1, 32'h80,  B80, 0)); // stall+excpt drops
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'h40,  0, 32'h80,  B80, 0));
      tv.push_back(mk(1, DBF, 0, 1, 32'h20, 0, 0,      1, 32'h40,  0, 32'h80,  B80, 0)); // rdy+jump in FETCH
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'h20,  0, 32'h80,  B80, 0));
      tv.push_back(mk(1, C20, 0, 0, 0,      0, 0,      1, 32'h20,  0, 32'h80,  B80, 0));
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'h20,  1, 32'h20,  C20, 0));
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'h24,  0, 32'h20,  C20, 0));
      tv.push_back(mk(0, 0,   0, 1, 32'h600, 0, 0,     1, 32'h24,  0, 32'h20,  C20, 0)); // jump -> DRAIN
      tv.push_back(mk(0, 0,   0, 1, 32'h700, 0, 0,     1, 32'h24,  0, 32'h20,  C20, 0)); // jump over jump
      tv.push_back(mk(1, DBF, 0, 0, 0,      0, 0,      1, 32'h24,  0, 32'h20,  C20, 0));
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'h700, 0, 32'h20,  C20, 0));
      tv.push_back(mk(1, D70, 0, 0, 0,      0, 0,      1, 32'h700, 0, 32'h20,  C20, 0));
      tv.push_back(mk(0, 0,   0, 1, 32'h600, 1, 32'h500, 0, 32'h700, 1, 32'h700, D70, 0)); // excpt beats jump
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'h500, 0, 32'h700, D70, 0));
      tv.push_back(mk(1, E50, 0, 0, 0,      0, 0,      1, 32'h500, 0, 32'h700, D70, 0));
      tv.push_back(mk(0, 0,   0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h500, 1, 32'h500, E50, 0));
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'hFFFF_FFFC, 0, 32'h500, E50, 0));
      tv.push_back(mk(1, FFC, 0, 0, 0,      0, 0,      1, 32'hFFFF_FFFC, 0, 32'h500, E50, 0));
      tv.push_back(mk(0, 0,   0, 0, 0,      0, 0,      0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, FFC, 0));
      tv.push_back(mk(1, X99, 0, 0, 0,      0, 0,      0, 32'h0,   0, 32'hFFFF_FFFC, FFC, 0)); // wrap, rdy in IDLE

      repeat (2) @(negedge clk);
      chk("reset_state", {ipc, inst, rom.rom_addr, rom.rom_ce, iv, err}, '0);
      rst = 1'b0;

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i]);
         #1;
         chk($sformatf("row%0d", i),
             {rom.rom_ce, rom.rom_addr, iv, ipc, inst, err},
             {tv[i].ce, tv[i].addr, tv[i].iv, tv[i].ipc, tv[i].ins, tv[i].err});
         @(negedge clk);
      end

      // ROM never answers: 15 waiting FETCH cycles, error pulse in IDLE, retry same address.
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 15; k++) begin
         #1;
         chk($sformatf("fetch_wait%0d", k), {rom.rom_ce, rom.rom_addr, iv, err}, {1'b1, 32'h0, 1'b0, 1'b0});
         @(negedge clk);
      end
      #1;
      chk("fetch_timeout_err", {rom.rom_ce, rom.rom_addr, iv, err}, {1'b0, 32'h0, 1'b0, 1'b1});
      @(negedge clk);

      // Redirect on the first waiting cycle, then the DRAIN times out and retries at the target.
      jce = 1'b1; jaddr = 32'h900;
      #1;
      chk("refetch_same", {rom.rom_ce, rom.rom_addr, err}, {1'b1, 32'h0, 1'b0});
      @(negedge clk);
      jce = 1'b0; jaddr = 32'h0;
      for (int k = 0; k < 14; k++) begin
         #1;
         chk($sformatf("drain_wait%0d", k), {rom.rom_ce, rom.rom_addr, err}, {1'b1, 32'h0, 1'b0});
         @(negedge clk);
      end
      #1;
      chk("drain_timeout_err", {rom.rom_ce, rom.rom_addr, err}, {1'b0, 32'h900, 1'b1});
      @(negedge clk);
      #1;
      chk("drain_retry", {rom.rom_ce, rom.rom_addr, err}, {1'b1, 32'h900, 1'b0});

      // Asynchronous reset between edges while a fetch is outstanding.
      #1 rst = 1'b1;
      #1;
      chk("async_reset", {ipc, inst, rom.rom_addr, rom.rom_ce, iv, err}, '0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_reset_idle", {rom.rom_ce, rom.rom_addr}, {1'b0, 32'h0});
      @(negedge clk);
      #1;
      chk("post_reset_fetch", {rom.rom_ce, rom.rom_addr}, {1'b1, 32'h0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
